packet_injector: RTL and testbench

- Transmit-side source for the 4-channel packet router: accepts packet requests from a host, encodes them into the 43-bit router packet format, queues them, and presents them to the router's data_in under the router's ready handshake.
- Sits directly upstream of the router. Its pkt_out drives router data_in; router ready drives router_ready.
- Guarantees that only well-formed packets reach the router. When there is no real work, the router sees the all-zero dummy packet.

---
 rtl/router_pkg.sv | 31 +++
 rtl/packet_injector_fifo.sv | 53 +++++
 rtl/packet_injector.sv | 70 +++++++
 tb/tb_packet_injector.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared packet-format definitions for the 4-channel router and its injector.
// Field positions, channel addresses and the dummy packet live here.
package router_pkg;

    localparam int CNT_HI  = 42;
    localparam int CNT_LO  = 40;
    localparam int ADDR_HI = 39;
    localparam int ADDR_LO = 24;
    localparam int PAY_HI  = 23;
    localparam int PAY_LO  = 0;
    localparam int PKT_W   = 43;

    localparam logic [15:0] ADDR_A = {8'd83, 8'd168};
    localparam logic [15:0] ADDR_B = {8'd170, 8'd153};
    localparam logic [15:0] ADDR_C = {8'd104, 8'd148};
    localparam logic [15:0] ADDR_D = {8'd188, 8'd39};

    localparam logic [PKT_W-1:0] PKT_NULL = '0;

    function automatic logic [15:0] dest_addr(input logic [1:0] dest);
        logic [15:0] a;
        case (dest)
            2'd0:    a = ADDR_A;
            2'd1:    a = ADDR_B;
            2'd2:    a = ADDR_C;
            default: a = ADDR_D;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/packet_injector_fifo.sv
// Synchronous packet queue holding fully encoded router packets.
// Head is the registered entry at rd_ptr; no write-to-read bypass.
module pkt_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PKT_W-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [PKT_W-1:0] head
);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic             do_wr;
    logic             do_rd;

    assign full  = (occ == (PTR_W+1)'(DEPTH));
    assign empty = (occ == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign head  = mem[rd_ptr];

    // Storage, pointers and occupancy; reset wipes the contents too.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/packet_injector.sv
// Host-side packet source: encodes requests, queues them, feeds the router.
// Only well-formed packets are queued; an empty queue shows the null packet.
module packet_injector
    import router_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [1:0]       push_dest,
    input  logic [2:0]       push_copies,
    input  logic [23:0]      push_payload,
    output logic             push_ready,
    input  logic             router_ready,
    output logic [PKT_W-1:0] pkt_out,
    output logic             pkt_valid,
    output logic [CNT_W-1:0] sent_count,
    output logic [CNT_W-1:0] reject_count
);

    logic             full;
    logic             empty;
    logic [PKT_W-1:0] head;
    logic [PKT_W-1:0] enc_pkt;
    logic             bad_copies;
    logic             accept;
    logic             reject;
    logic             consume;

    assign enc_pkt    = {push_copies, dest_addr(push_dest), push_payload};
    assign bad_copies = (push_copies == 3'd0);
    assign accept     = push && !bad_copies && !full;
    assign reject     = push && (bad_copies || full);
    assign consume    = router_ready && !empty;

    assign push_ready = !full;
    assign pkt_valid  = !empty;
    assign pkt_out    = empty ? PKT_NULL : head;

    pkt_fifo #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (accept),
        .wr_data(enc_pkt),
        .rd_en  (consume),
        .full   (full),
        .empty  (empty),
        .head   (head)
    );

    // Saturating statistics for consumed packets and rejected pushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_count   <= '0;
            reject_count <= '0;
        end else begin
            if (consume && (sent_count != '1))
                sent_count <= sent_count + 1'b1;
            if (reject && (reject_count != '1))
                reject_count <= reject_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_packet_injector.sv
// Directed self-checking bench for packet_injector.
// Inputs change on negedge; outputs are sampled on the following negedge.
module tb_packet_injector;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic [1:0]  push_dest;
    logic [2:0]  push_copies;
    logic [23:0] push_payload;
    logic        push_ready;
    logic        router_ready;
    logic [42:0] pkt_out;
    logic        pkt_valid;
    logic [7:0]  sent_count;
    logic [7:0]  reject_count;

    int checks   = 0;
    int failures = 0;
    int exp_sent = 0;
    int exp_rej  = 0;

    always #5 clk = ~clk;

    packet_injector dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_dest   (push_dest),
        .push_copies (push_copies),
        .push_payload(push_payload),
        .push_ready  (push_ready),
        .router_ready(router_ready),
        .pkt_out     (pkt_out),
        .pkt_valid   (pkt_valid),
        .sent_count  (sent_count),
        .reject_count(reject_count)
    );

    function automatic logic [42:0] mk(input logic [1:0] d,
                                       input logic [2:0] c,
                                       input logic [23:0] p);
        logic [15:0] a;
        case (d)
            2'd0:    a = {8'd83, 8'd168};
            2'd1:    a = {8'd170, 8'd153};
            2'd2:    a = {8'd104, 8'd148};
            default: a = {8'd188, 8'd39};
        endcase
        return {c, a, p};
    endfunction

    task automatic set_push(input logic p, input logic [1:0] d,
                            input logic [2:0] c, input logic [23:0] pl);
        push         = p;
        push_dest    = d;
        push_copies  = c;
        push_payload = pl;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        router_ready = 1'b0;
        set_push(1'b0, 2'd0, 3'd0, 24'd0);
        step(); step();
        rst = 1'b0;
        router_ready = 1'b1;
        repeat (5) step();
        checks++;
        if (pkt_out !== 43'd0) begin
            failures++;
            $display("FAIL reset_pkt_out got=%h exp=0", pkt_out);
        end
        checks++;
        if (pkt_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", pkt_valid);
        end
        checks++;
        if (push_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_push_ready got=%b exp=1", push_ready);
        end
        checks++;
        if (sent_count !== 8'd0 || reject_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_counts sent=%0d rej=%0d exp=0/0",
                     sent_count, reject_count);
        end
    endtask

    task automatic test_single();
        logic [42:0] e;
        e = {3'd3, 8'd83, 8'd168, 24'hABCDEF};
        router_ready = 1'b0;
        set_push(1'b1, 2'd0, 3'd3, 24'hABCDEF);
        step();
        set_push(1'b0, 2'd0, 3'd0, 24'd0);
        checks++;
        if (pkt_out !== e || pkt_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_head got=%h/%b exp=%h/1",
                     pkt_out, pkt_valid, e);
        end
        router_ready = 1'b1;
        step();
        exp_sent++;
        router_ready = 1'b0;
        checks++;
        if (pkt_valid !== 1'b0 || sent_count !== 8'(exp_sent)) begin
            failures++;
            $display("FAIL single_consume valid=%b sent=%0d exp=0/%0d",
                     pkt_valid, sent_count, exp_sent);
        end
    endtask

    task automatic test_zero_copies();
        set_push(1'b1, 2'd2, 3'd0, 24'h123456);
        step();
        set_push(1'b0, 2'd0, 3'd0, 24'd0);
        exp_rej++;
        checks++;
        if (pkt_valid !== 1'b0 || pkt_out !== 43'd0) begin
            failures++;
            $display("FAIL zero_copies_queue valid=%b pkt=%h exp=0/0",
                     pkt_valid, pkt_out);
        end
        checks++;
        if (reject_count !== 8'(exp_rej)) begin
            failures++;
            $display("FAIL zero_copies_rej got=%0d exp=%0d",
                     reject_count, exp_rej);
        end
    endtask

    task automatic test_full_drain();
        logic [42:0] e [4];
        logic [1:0]  d;
        router_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 2'(i % 4);
            set_push(1'b1, d, 3'(i + 1), 24'h100 + 24'(i));
            if (i < 4) e[i] = mk(d, 3'(i + 1), 24'h100 + 24'(i));
            step();
            if (i == 3) begin
                checks++;
                if (push_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL full_ready got=%b exp=0", push_ready);
                end
            end
        end
        set_push(1'b0, 2'd0, 3'd0, 24'd0);
        exp_rej++;
        checks++;
        if (reject_count !== 8'(exp_rej)) begin
            failures++;
            $display("FAIL full_reject got=%0d exp=%0d",
                     reject_count, exp_rej);
        end
        router_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pkt_out !== e[i] || pkt_valid !== 1'b1) begin
                failures++;
                $display("FAIL drain_%0d got=%h exp=%h", i, pkt_out, e[i]);
            end
            step();
            exp_sent++;
        end
        router_ready = 1'b0;
        checks++;
        if (pkt_valid !== 1'b0 || sent_count !== 8'(exp_sent)) begin
            failures++;
            $display("FAIL drain_end valid=%b sent=%0d exp=0/%0d",
                     pkt_valid, sent_count, exp_sent);
        end
    endtask

    task automatic test_back_to_back();
        logic [42:0] p [7];
        for (int i = 0; i < 7; i++)
            p[i] = mk(2'(3 - (i % 4)), 3'd5, 24'hC00 + 24'(i));
        router_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_push(1'b1, 2'(3 - i), 3'd5, 24'hC00 + 24'(i));
            step();
        end
        set_push(1'b1, 2'd1, 3'd5, 24'hC02);
        router_ready = 1'b1;
        step();
        exp_sent++;
        checks++;
        if (pkt_out !== p[1] || push_ready !== 1'b1) begin
            failures++;
            $display("FAIL simul_head got=%h/%b exp=%h/1",
                     pkt_out, push_ready, p[1]);
        end
        router_ready = 1'b0;
        for (int i = 3; i < 5; i++) begin
            set_push(1'b1, 2'(3 - (i % 4)), 3'd5, 24'hC00 + 24'(i));
            step();
        end
        checks++;
        if (push_ready !== 1'b0) begin
            failures++;
            $display("FAIL simul_full got=%b exp=0", push_ready);
        end
        set_push(1'b1, 2'd2, 3'd5, 24'hC05);
        router_ready = 1'b1;
        step();
        exp_sent++;
        exp_rej++;
        checks++;
        if (reject_count !== 8'(exp_rej) || pkt_out !== p[2]) begin
            failures++;
            $display("FAIL full_consume rej=%0d pkt=%h exp=%0d/%h",
                     reject_count, pkt_out, exp_rej, p[2]);
        end
        set_push(1'b1, 2'd1, 3'd5, 24'hC06);
        step();
        exp_sent++;
        set_push(1'b0, 2'd0, 3'd0, 24'd0);
        for (int i = 3; i < 7; i++) begin
            if (i == 5) continue;
            checks++;
            if (pkt_out !== p[i]) begin
                failures++;
                $display("FAIL wrap_order_%0d got=%h exp=%h",
                         i, pkt_out, p[i]);
            end
            step();
            exp_sent++;
        end
        router_ready = 1'b0;
        checks++;
        if (pkt_valid !== 1'b0 || sent_count !== 8'(exp_sent)) begin
            failures++;
            $display("FAIL wrap_end valid=%b sent=%0d exp=0/%0d",
                     pkt_valid, sent_count, exp_sent);
        end
    endtask

    task automatic test_reset_mid();
        router_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 2'(i), 3'd2, 24'hD00 + 24'(i));
            step();
        end
        rst = 1'b1;
        router_ready = 1'b1;
        set_push(1'b1, 2'd3, 3'd2, 24'hDDD);
        step();
        rst = 1'b0;
        set_push(1'b0, 2'd0, 3'd0, 24'd0);
        exp_sent = 0;
        exp_rej  = 0;
        checks++;
        if (pkt_out !== 43'd0 || pkt_valid !== 1'b0
            || push_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_out pkt=%h v=%b r=%b exp=0/0/1",
                     pkt_out, pkt_valid, push_ready);
        end
        checks++;
        if (sent_count !== 8'd0 || reject_count !== 8'd0) begin
            failures++;
            $display("FAIL midrst_counts sent=%0d rej=%0d exp=0/0",
                     sent_count, reject_count);
        end
        step();
        checks++;
        if (pkt_valid !== 1'b0 || sent_count !== 8'd0) begin
            failures++;
            $display("FAIL midrst_push_ignored v=%b sent=%0d exp=0/0",
                     pkt_valid, sent_count);
        end
        router_ready = 1'b0;
    endtask

    task automatic test_saturation();
        router_ready = 1'b0;
        set_push(1'b1, 2'd1, 3'd0, 24'd7);
        repeat (300) step();
        checks++;
        if (reject_count !== 8'd255) begin
            failures++;
            $display("FAIL rej_saturate got=%0d exp=255", reject_count);
        end
        set_push(1'b1, 2'd2, 3'd1, 24'd9);
        router_ready = 1'b1;
        repeat (300) step();
        set_push(1'b0, 2'd0, 3'd0, 24'd0);
        step();
        checks++;
        if (sent_count !== 8'd255 || reject_count !== 8'd255) begin
            failures++;
            $display("FAIL sent_saturate sent=%0d rej=%0d exp=255/255",
                     sent_count, reject_count);
        end
        checks++;
        if (pkt_valid !== 1'b0) begin
            failures++;
            $display("FAIL sat_drained got=%b exp=0", pkt_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_copies();
        test_full_drain();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
